mac_spike_scheduler: RTL
========================

MAC_SPIKE_SCHEDULER -- requirements
Module: mac_spike_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of spike requesters sharing one MAC.
REQ-002 Parameter ADDR_W, default 12: source address width.
REQ-003 Parameter TIMESTEP_CYCLES, default 4: clocks per timestep, including the clear cycle; legal range 2..255.
REQ-004 Parameter INIT_CYCLES, default 2: clocks `mac_set` is held after reset; legal range 1..255.
REQ-005 Parameter IDLE_ADDR, default 12'hFFF: address driven when no spike is issued; never a configured synapse address.
REQ-006 CLK_Mac  input  1  single clock; all logic on its rising edge.
REQ-007 RST_Mac  input  1  reset, synchronous, active-high.
REQ-008 req_valid  input  NUM_REQ  per-requester spike present.
REQ-009 req_addr  input  NUM_REQ*ADDR_W  per-requester source address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 req_ready  output  NUM_REQ  one-hot grant; a spike transfers when req_valid[i] and req_ready[i] are both high.
REQ-011 mac_set  output  1  MAC initialisation level.
REQ-012 mac_clear  output  1  end-of-timestep pulse to the MAC.
REQ-013 mac_source_address  output  ADDR_W  registered address to the MAC.
REQ-014 mac_addr_valid  output  1  high when mac_source_address carries a granted spike.
REQ-015 timestep  output  16  count of completed timesteps; wraps at 16'hFFFF -> 0.

Function
REQ-016 FSM states: INIT, RUN, CLOSE.
REQ-017 INIT: mac_set=1 for exactly INIT_CYCLES clocks, then go to RUN; no grants are issued in INIT.
REQ-018 RUN lasts TIMESTEP_CYCLES-1 clocks, counted by a phase counter; it then goes to CLOSE.
REQ-019 CLOSE lasts 1 clock: mac_clear=1, no grant, timestep increments, phase counter resets; it then returns to RUN.
REQ-020 In RUN, at most one grant per clock is issued, round-robin over req_valid.
REQ-021 The search starts at the index after the last granted requester; the pointer is unchanged on cycles with no grant.
REQ-022 req_ready is combinational from the registered pointer, req_valid and state; it is all-zero outside RUN.
REQ-023 A granted address appears on mac_source_address with mac_addr_valid=1 on the clock after the transfer (1-cycle latency).
REQ-024 On every other clock, mac_source_address=IDLE_ADDR and mac_addr_valid=0.
REQ-025 When two consecutive grants carry the same address, IDLE_ADDR is inserted for 1 clock between them, so the level-sensitive MAC sees two edges.
REQ-026 The duplicate insertion stalls grants for that clock, and the round-robin pointer holds.
REQ-027 A transfer on the last RUN clock is presented during CLOSE and counts toward the timestep just closing.
REQ-028 A request pending in INIT or CLOSE is held by the requester and not lost; its req_ready stays 0.
REQ-029 mac_set and mac_clear are never high in the same clock.

Reset
REQ-030 While RST_Mac=1: state=INIT, phase=0, pointer=0, timestep=0, mac_set=0, mac_clear=0, mac_addr_valid=0, mac_source_address=IDLE_ADDR, req_ready=0.
REQ-031 On the first clock after RST_Mac falls, INIT begins and mac_set=1.
REQ-032 Reset asserted mid-RUN or mid-CLOSE aborts the timestep, and any in-flight granted address is discarded.

Configuration
REQ-033 Macro MAC_SPIKE_SCHEDULER_STATS_EN, when defined, adds output spike_count [15:0]: grants in the last completed timestep.
REQ-034 spike_count is latched in CLOSE, saturates at 16'hFFFF, and resets to 0.
REQ-035 When the macro is undefined, the port and its counters are absent, and all other behaviour is identical.

Verification
REQ-036 Reset release with defaults -> mac_set=1 for 2 clocks, then RUN; mac_clear pulses every 4th clock thereafter; timestep=1 after the first pulse.
REQ-037 All 4 requesters valid continuously, addresses 8,9,10,11 -> grants 0,1,2,3 in rotation, 3 per timestep; requester 3 is granted in the 2nd timestep; no starvation.
REQ-038 Requester 0 sends address 12 twice back-to-back -> MAC sees 12, FFF, 12; pointer holds during the gap.
REQ-039 Spike valid during CLOSE or INIT -> req_ready=0; the spike is granted on the first RUN clock and the address appears 1 clock later.
REQ-040 RST_Mac pulsed for 1 clock mid-RUN while an address is on the bus -> next clock shows IDLE_ADDR, valid=0, timestep=0, and INIT restarts.
REQ-041 With STATS_EN, 3 grants in timestep 1 and 0 in timestep 2 -> spike_count=3 after the 1st clear and 0 after the 2nd.

Source files
------------

// File: rtl/mac_spike_scheduler_if.sv
// Spike request and MAC-side bundle for mac_spike_scheduler.
// Optional spike_count appears when MAC_SPIKE_SCHEDULER_STATS_EN is defined.
interface mac_spike_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      mac_set;
    logic                      mac_clear;
    logic [ADDR_W-1:0]         mac_source_address;
    logic                      mac_addr_valid;
    logic [15:0]               timestep;
`ifdef MAC_SPIKE_SCHEDULER_STATS_EN
    logic [15:0]               spike_count;
`endif

    modport slave (
        input  req_valid,
        input  req_addr,
`ifdef MAC_SPIKE_SCHEDULER_STATS_EN
        output spike_count,
`endif
        output req_ready,
        output mac_set,
        output mac_clear,
        output mac_source_address,
        output mac_addr_valid,
        output timestep
    );

    modport master (
        output req_valid,
        output req_addr,
`ifdef MAC_SPIKE_SCHEDULER_STATS_EN
        input  spike_count,
`endif
        input  req_ready,
        input  mac_set,
        input  mac_clear,
        input  mac_source_address,
        input  mac_addr_valid,
        input  timestep
    );
endinterface

// File: rtl/mac_spike_scheduler.sv
// Round-robin spike scheduler feeding one level-sensitive MAC per timestep.
// Define MAC_SPIKE_SCHEDULER_STATS_EN to add the spike_count output.
module mac_spike_scheduler #(
    parameter int                NUM_REQ         = 4,
    parameter int                ADDR_W          = 12,
    parameter int                TIMESTEP_CYCLES = 4,
    parameter int                INIT_CYCLES     = 2,
    parameter logic [ADDR_W-1:0] IDLE_ADDR       = {ADDR_W{1'b1}}
) (
    input  logic                  CLK_Mac,
    input  logic                  RST_Mac,
    mac_spike_scheduler_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_CLOSE
    } state_t;

    state_t             state;
    logic [7:0]         init_cnt;
    logic [7:0]         phase;
    logic [PTR_W-1:0]   ptr;
    logic [15:0]        ts_q;
    logic               set_q;
    logic               clear_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               av_q;

    logic [ADDR_W-1:0]  addr_a [NUM_REQ];
    logic [PTR_W:0]     srch;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W-1:0]   gnt_idx;
    logic               found;
    logic               dup;
    logic [NUM_REQ-1:0] ready;
    logic               gnt_fire;
    logic [ADDR_W-1:0]  gnt_addr;
    logic [PTR_W-1:0]   ptr_nxt;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end

    // Pick the first valid requester at or after the pointer; stall on a repeat address.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        srch    = '0;
        idx     = '0;
        ready   = '0;
        dup     = 1'b0;
        if (!RST_Mac && state == S_RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                srch = {1'b0, ptr} + (PTR_W+1)'(k);
                if (srch >= (PTR_W+1)'(NUM_REQ)) begin
                    srch = srch - (PTR_W+1)'(NUM_REQ);
                end
                idx = srch[PTR_W-1:0];
                if (!found && bus.req_valid[idx]) begin
                    found   = 1'b1;
                    gnt_idx = idx;
                end
            end
            dup = av_q && (addr_a[gnt_idx] == addr_q);
            ready[gnt_idx] = found && !dup;
        end
    end

    assign gnt_fire = |ready;
    assign gnt_addr = addr_a[gnt_idx];
    assign ptr_nxt  = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

    // Timestep FSM with registered MAC outputs and the round-robin pointer.
    always_ff @(posedge CLK_Mac) begin
        if (RST_Mac) begin
            state    <= S_INIT;
            init_cnt <= '0;
            phase    <= '0;
            ptr      <= '0;
            ts_q     <= '0;
            set_q    <= 1'b0;
            clear_q  <= 1'b0;
            addr_q   <= IDLE_ADDR;
            av_q     <= 1'b0;
        end else begin
            av_q   <= gnt_fire;
            addr_q <= gnt_fire ? gnt_addr : IDLE_ADDR;
            if (gnt_fire) begin
                ptr <= ptr_nxt;
            end
            unique case (state)
                S_INIT: begin
                    if (init_cnt == 8'(INIT_CYCLES)) begin
                        state <= S_RUN;
                        set_q <= 1'b0;
                        phase <= '0;
                    end else begin
                        init_cnt <= init_cnt + 8'd1;
                        set_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (phase == 8'(TIMESTEP_CYCLES-2)) begin
                        state   <= S_CLOSE;
                        clear_q <= 1'b1;
                        phase   <= '0;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                S_CLOSE: begin
                    state   <= S_RUN;
                    clear_q <= 1'b0;
                    phase   <= '0;
                    ts_q    <= ts_q + 16'd1;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    assign bus.req_ready          = ready;
    assign bus.mac_set            = set_q;
    assign bus.mac_clear          = clear_q;
    assign bus.mac_source_address = addr_q;
    assign bus.mac_addr_valid     = av_q;
    assign bus.timestep           = ts_q;

`ifdef MAC_SPIKE_SCHEDULER_STATS_EN
    logic [15:0] run_cnt;
    logic [15:0] sc_q;

    // Count grants in the open timestep and publish the total when it closes.
    always_ff @(posedge CLK_Mac) begin
        if (RST_Mac) begin
            run_cnt <= '0;
            sc_q    <= '0;
        end else if (state == S_CLOSE) begin
            sc_q    <= run_cnt;
            run_cnt <= '0;
        end else if (gnt_fire && run_cnt != 16'hFFFF) begin
            run_cnt <= run_cnt + 16'd1;
        end
    end

    assign bus.spike_count = sc_q;
`endif

endmodule
